// File: rtl/audio_pkg.sv
// audio_pkg: shared definitions for the audio datapath blocks.
//   SAMPLE_W_DEF   default bits per channel sample
//   FRAME_BCLKS    bit clocks per stereo frame at the serializer
//   stereo_pair_t  one left/right sample pair, as produced by the sound sources
package audio_pkg;

  localparam int unsigned SAMPLE_W_DEF = 24;
  localparam int unsigned FRAME_BCLKS  = 256;

  typedef struct packed {
    logic [SAMPLE_W_DEF-1:0] left;
    logic [SAMPLE_W_DEF-1:0] right;
  } stereo_pair_t;

endpackage

// File: rtl/audio_lrclk_sync.sv
// audio_lrclk_sync: brings the serializer's asynchronous daclrc into the
// system clock domain and produces one-cycle edge pulses.
// Ports:
//   sys_clk    in   system clock
//   sys_rst_n  in   asynchronous active-low reset
//   daclrc     in   serializer word clock (0 = left half, 1 = right half)
//   lr_rise    out  one-cycle pulse, synchronized daclrc 0->1
//   lr_fall    out  one-cycle pulse, synchronized daclrc 1->0
module audio_lrclk_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic daclrc,
  output logic lr_rise,
  output logic lr_fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] fill_q;
  logic                   lr_q;
  logic                   primed_q;
  logic                   lr_s;

  assign lr_s = sync_q[SYNC_STAGES-1];

  // fill_q tracks how far real samples have propagated through the
  // synchronizer since reset release. Edges are reported only once lr_q holds
  // a genuine sample, so a daclrc already high at release does not look like
  // a 0->1 transition against the reset value of the flops.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q   <= '0;
      fill_q   <= '0;
      lr_q     <= 1'b0;
      primed_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], daclrc};
      fill_q   <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      lr_q     <= lr_s;
      primed_q <= fill_q[SYNC_STAGES-1];
    end
  end

  always_comb begin
    lr_rise = primed_q &  lr_s & ~lr_q;
    lr_fall = primed_q & ~lr_s &  lr_q;
  end

endmodule

// File: rtl/audio_sample_fifo.sv
// audio_sample_fifo: stereo sample buffer feeding the I2S DAC serializer.
// Pairs arrive over valid/ready, are queued in a circular buffer, and are
// released to the serializer one per frame: the left word on the daclrc rise
// (left half done), the right word via a shadow register on the daclrc fall.
// Ports:
//   sys_clk, sys_rst_n    clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake, transfer when both high
//   in_left, in_right     input sample pair (two's complement)
//   daclrc                serializer word clock, asynchronous
//   data_left/data_right  words presented to the serializer
//   level                 pairs currently stored, 0..DEPTH
//   underflow             sticky, a frame found the FIFO empty
//   underflow_clr         pulse, clears underflow (a new event wins)
module audio_sample_fifo
  import audio_pkg::*;
#(
  parameter int unsigned SAMPLE_W    = SAMPLE_W_DEF,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SAMPLE_W-1:0]      in_left,
  input  logic [SAMPLE_W-1:0]      in_right,
  input  logic                     daclrc,
  output logic [SAMPLE_W-1:0]      data_left,
  output logic [SAMPLE_W-1:0]      data_right,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     underflow,
  input  logic                     underflow_clr
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [SAMPLE_W-1:0] mem_left  [DEPTH];
  logic [SAMPLE_W-1:0] mem_right [DEPTH];

  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [SAMPLE_W-1:0] shadow_right;

  logic lr_rise;
  logic lr_fall;
  logic push;
  logic pop;
  logic starve;
  logic fifo_empty;

  audio_lrclk_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_lrclk_sync (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .daclrc   (daclrc),
    .lr_rise  (lr_rise),
    .lr_fall  (lr_fall)
  );

  always_comb begin
    fifo_empty = (level == '0);
    in_ready   = (level != FULL_LVL);
    push       = in_valid & in_ready;
    // A pair pushed in the same cycle as a rise on an empty FIFO is not
    // forwarded: the frame is muted and the pair waits for the next rise.
    pop        = lr_rise & ~fifo_empty;
    starve     = lr_rise &  fifo_empty;
  end

  // Sample storage carries no reset; only pointers and level define content.
  always_ff @(posedge sys_clk) begin
    if (push) begin
      mem_left[wr_ptr]  <= in_left;
      mem_right[wr_ptr] <= in_right;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      data_left    <= '0;
      shadow_right <= '0;
      data_right   <= '0;
    end else begin
      if (pop) begin
        data_left    <= mem_left[rd_ptr];
        shadow_right <= mem_right[rd_ptr];
      end else if (starve) begin
        data_left    <= '0;
        shadow_right <= '0;
      end
      if (lr_fall) begin
        data_right <= shadow_right;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      underflow <= 1'b0;
    end else if (starve) begin
      underflow <= 1'b1;
    end else if (underflow_clr) begin
      underflow <= 1'b0;
    end
  end

endmodule
